measure_ctrl: RTL and testbench
===============================

// Module: measure_ctrl
// PURPOSE
//  Sequencer/consumer for the measure block: issues gate_st/gate_time to start a
//  frequency measurement, waits for the 64-bit result write (reg_wr_en/reg_wr_data),
//  buffers it and presents it to the host side on a valid/ready stream.
//  Adds single-shot/continuous modes, watchdog timeout and error flags.
// PARAMETERS
//  DATA_W   64   result width; must match measure reg_wr_data
//  GATE_W    8   gate time code width
//  TMO_W    32   timeout counter width
// PORTS
//  clk_i          in   1       system clock; single clock domain
//  rst_n_i        in   1       asynchronous, active-low reset
//  start_i        in   1       1-cycle start request; ignored while busy_o=1
//  stop_i         in   1       clears continuous mode; current measurement completes
//  cont_i         in   1       continuous mode, sampled with start_i
//  gate_time_i    in   GATE_W  gate code, sampled with start_i
//  timeout_i      in   TMO_W   watchdog limit in clk cycles; 0 disables
//  clr_i          in   1       clears timeout_o/stray_o
//  gate_st_o      out  1       gate start pulse to measure
//  gate_time_o    out  GATE_W  latched gate code, stable from ARM until return to IDLE
//  reg_wr_en_i    in   1       result strobe from measure
//  reg_wr_data_i  in   DATA_W  result data from measure
//  res_valid_o    out  1       result available
//  res_ready_i    in   1       host accepts result when valid&ready
//  res_data_o     out  DATA_W  result data
//  busy_o         out  1       state != IDLE
//  timeout_o      out  1       sticky: watchdog expired
//  stray_o        out  1       sticky: reg_wr_en_i outside WAIT
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, cont latch 0, counter 0; reset mid-operation aborts
//   immediately, held result discarded.
//  FSM IDLE->ARM->WAIT->HOLD->{ARM|IDLE}. All outputs registered.
//  IDLE: start_i -> latch gate_time_i, cont_i; ARM next cycle.
//  ARM: gate_st_o=1 exactly one cycle (start_i to gate_st_o latency 1); counter cleared; ->WAIT.
//  WAIT: counter +1/cycle. reg_wr_en_i -> capture data, res_valid_o=1 next cycle, ->HOLD.
//   timeout_i!=0 and counter==timeout_i-1 -> timeout_o=1, ->IDLE, no result.
//   reg_wr_en_i same cycle as expiry: result wins, no timeout.
//  HOLD: res_valid_o/res_data_o stable until valid&ready; on handshake -> ARM if cont latch
//   else IDLE. No new gate while result unconsumed.
//  stop_i in any state clears cont latch; start_i while busy ignored.
//  reg_wr_en_i outside WAIT: data dropped, stray_o=1. clr_i clears flags; set wins over clr.
//  Counter saturates at all-ones (no wrap).
// CONFIGURATION
//  MEASURE_CTRL_FIFO_EN defined: 4-entry result FIFO replaces holding register; WAIT capture
//   pushes, then ->ARM (cont) or IDLE; if FIFO full after push, wait in HOLD until a pop
//   frees space before ARM. busy_o excludes FIFO occupancy. Result order preserved.
//  Undefined: single holding register, behaviour as above.
// STRUCTURE
//  measure_pkg: DATA_W/GATE_W constants, ctrl_state_t enum {IDLE,ARM,WAIT,HOLD}.
//  Sub-module result_fifo (depth 4, fall-through valid/ready), instantiated only with the macro.
// TESTING
//  1 Single shot: gate_time_i=8'h0a, start -> gate_st_o 1 cycle later for 1 cycle,
//    gate_time_o=8'h0a; reg_wr_en_i with 64'h0000_0001_0000_00c8 after 200 cycles ->
//    res_valid_o next cycle, data equal; ready=1 -> busy_o=0 next cycle.
//  2 Backpressure: res_ready_i=0 for 50 cycles -> res_valid_o/res_data_o stable, no gate_st_o.
//  3 Timeout: timeout_i=100, no result -> timeout_o=1 after 100 WAIT cycles, IDLE,
//    res_valid_o=0; clr_i -> timeout_o=0. Result on expiry cycle -> result, no timeout.
//  4 Continuous: cont_i=1, ready=1, 3 results -> 3 gate_st_o pulses, each 1 cycle after
//    handshake; stop_i during 3rd WAIT -> result delivered, then IDLE.
//  5 Stray/reset: reg_wr_en_i in IDLE -> stray_o=1, no valid; rst_n_i low in WAIT -> all 0.
//  6 FIFO_EN: cont=1, ready=0 -> 4 results buffered, no 5th gate until one pop, order kept.

Source files
------------

// File: rtl/measure_ctrl_pkg.sv
// Shared constants and types for the measure sequencer.
// FIFO sizing is only used when MEASURE_CTRL_FIFO_EN is defined.
package measure_ctrl_pkg;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned GATE_W    = 8;
  localparam int unsigned FifoDepth = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StWait = 2'd2,
    StHold = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/measure_ctrl_if.sv
// Measure-side gate/result signals plus the host-side result stream.
// master = sequencer (measure_ctrl), slave = measure block and host.
interface measure_ctrl_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned GATE_W = 8
);
  logic              gate_st;
  logic [GATE_W-1:0] gate_time;
  logic              reg_wr_en;
  logic [DATA_W-1:0] reg_wr_data;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;

  modport master (
    output gate_st, gate_time, res_valid, res_data,
    input  reg_wr_en, reg_wr_data, res_ready
  );

  modport slave (
    input  gate_st, gate_time, res_valid, res_data,
    output reg_wr_en, reg_wr_data, res_ready
  );
endinterface

// File: rtl/measure_ctrl_result_fifo.sv
// Small fall-through result FIFO; head is visible whenever valid_o is high.
// Depth must be a power of two so the pointers wrap naturally.
module measure_ctrl_result_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  cnt_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_ok, pop_ok;

  assign pop_ok  = pop_i && (cnt_q != '0);
  assign push_ok = push_i && ((cnt_q != CntW'(Depth)) || pop_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (pop_ok) rptr_q <= rptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rptr_q];
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/measure_ctrl.sv
// Measurement sequencer: starts a gate, waits for the result, hands it to the host stream.
// Define MEASURE_CTRL_FIFO_EN to replace the holding register with a 4-entry result FIFO.
module measure_ctrl
  import measure_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = measure_ctrl_pkg::DATA_W,
  parameter int unsigned GATE_W = measure_ctrl_pkg::GATE_W,
  parameter int unsigned TMO_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              cont_i,
  input  logic [GATE_W-1:0] gate_time_i,
  input  logic [TMO_W-1:0]  timeout_i,
  input  logic              clr_i,
  measure_ctrl_if.master    bus,
  output logic              busy_o,
  output logic              timeout_o,
  output logic              stray_o
);

  ctrl_state_t       state_q, state_d;
  logic [GATE_W-1:0] gate_time_q, gate_time_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              cont_q, cont_d;
  logic              timeout_q, timeout_d;
  logic              stray_q, stray_d;
  logic              gate_st_q, busy_q;
  logic              capture, expire, cont_go;
  logic              start_ok, hold_release;
  ctrl_state_t       after_capture;

  assign capture = (state_q == StWait) && bus.reg_wr_en;
  // A result arriving on the expiry cycle takes priority over the watchdog.
  assign expire  = (state_q == StWait) && (timeout_i != '0) && !bus.reg_wr_en &&
                   (cnt_q == timeout_i - TMO_W'(1));
  assign cont_go = cont_q && !stop_i;

`ifdef MEASURE_CTRL_FIFO_EN
  localparam int unsigned CntW = $clog2(FifoDepth) + 1;

  logic [CntW-1:0]   fifo_cnt;
  logic              fifo_valid, fifo_pop, fifo_full, full_after_push;
  logic [DATA_W-1:0] fifo_data;

  assign fifo_pop        = fifo_valid && bus.res_ready;
  assign fifo_full       = (fifo_cnt == CntW'(FifoDepth));
  assign full_after_push = (fifo_cnt == CntW'(FifoDepth - 1)) && !fifo_pop;
  // A start with no free slot would lose its result, so it is held off.
  assign start_ok        = !fifo_full;
  assign hold_release    = !fifo_full;
  assign after_capture   = !cont_go ? StIdle : (full_after_push ? StHold : StArm);

  measure_ctrl_result_fifo #(
    .Width (DATA_W),
    .Depth (FifoDepth)
  ) u_result_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_n_i),
    .push_i  (capture),
    .data_i  (bus.reg_wr_data),
    .pop_i   (fifo_pop),
    .valid_o (fifo_valid),
    .data_o  (fifo_data),
    .cnt_o   (fifo_cnt)
  );

  assign bus.res_valid = fifo_valid;
  assign bus.res_data  = fifo_data;
`else
  logic              res_valid_q;
  logic [DATA_W-1:0] res_data_q;

  assign start_ok      = 1'b1;
  assign hold_release  = res_valid_q && bus.res_ready;
  assign after_capture = StHold;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= (state_d == StHold);
      if (capture) res_data_q <= bus.reg_wr_data;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
`endif

  always_comb begin
    state_d     = state_q;
    gate_time_d = gate_time_q;
    cont_d      = cont_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    stray_d     = stray_q;

    if (clr_i) begin
      timeout_d = 1'b0;
      stray_d   = 1'b0;
    end
    if (bus.reg_wr_en && (state_q != StWait)) stray_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start_i && start_ok) begin
          gate_time_d = gate_time_i;
          cont_d      = cont_i;
          state_d     = StArm;
        end
      end
      StArm: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q != '1) cnt_d = cnt_q + TMO_W'(1);
        if (capture) begin
          state_d = after_capture;
        end else if (expire) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StHold: begin
        if (hold_release) state_d = cont_go ? StArm : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (stop_i) cont_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      gate_time_q <= '0;
      cont_q      <= 1'b0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      stray_q     <= 1'b0;
      gate_st_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_time_q <= gate_time_d;
      cont_q      <= cont_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      stray_q     <= stray_d;
      gate_st_q   <= (state_d == StArm);
      busy_q      <= (state_d != StIdle);
    end
  end

  assign bus.gate_st   = gate_st_q;
  assign bus.gate_time = gate_time_q;
  assign busy_o        = busy_q;
  assign timeout_o     = timeout_q;
  assign stray_o       = stray_q;

endmodule

// File: tb/tb_measure_ctrl.sv
// Directed bench for measure_ctrl: single shot, backpressure, timeout, continuous, stray/reset,
// and the FIFO build when MEASURE_CTRL_FIFO_EN is defined.
module tb_measure_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, cont, clr;
  logic [7:0]  gate_time;
  logic [31:0] timeout;
  logic        busy, tmo, stray;
  int          checks = 0;
  int          failures = 0;

  measure_ctrl_if #(.DATA_W(64), .GATE_W(8)) bus ();

  measure_ctrl #(.DATA_W(64), .GATE_W(8), .TMO_W(32)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .stop_i      (stop),
    .cont_i      (cont),
    .gate_time_i (gate_time),
    .timeout_i   (timeout),
    .clr_i       (clr),
    .bus         (bus.master),
    .busy_o      (busy),
    .timeout_o   (tmo),
    .stray_o     (stray)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start in IDLE; returns just after the edge that enters ARM.
  task automatic kick(input logic [7:0] g, input logic c);
    gate_time = g;
    cont      = c;
    start     = 1'b1;
    tick();
    start = 1'b0;
    cont  = 1'b0;
  endtask

  task automatic result(input logic [63:0] d);
    bus.reg_wr_en   = 1'b1;
    bus.reg_wr_data = d;
    tick();
    bus.reg_wr_en = 1'b0;
  endtask

  initial begin
    int bad;
    logic [63:0] held;
    rst_n = 1'b0; start = 0; stop = 0; cont = 0; clr = 0;
    gate_time = '0; timeout = '0;
    bus.reg_wr_en = 0; bus.reg_wr_data = '0; bus.res_ready = 0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_valid", bus.res_valid, 0);
    check("rst_gate_st", bus.gate_st, 0);
    check("rst_flags", {tmo, stray}, 2'b00);
    rst_n = 1'b1;
    tick();

    // Single shot
    kick(8'h0a, 1'b0);
    check("t1_gate_st", bus.gate_st, 1);
    check("t1_gate_time", bus.gate_time, 8'h0a);
    check("t1_busy", busy, 1);
    tick();
    check("t1_gate_st_one", bus.gate_st, 0);
    bad = 0;
    for (int i = 0; i < 198; i++) begin
      tick();
      if (bus.gate_st || bus.res_valid) bad++;
    end
    check("t1_quiet_wait", bad, 0);
    result(64'h0000_0001_0000_00c8);
    check("t1_valid", bus.res_valid, 1);
    check("t1_data", bus.res_data, 64'h0000_0001_0000_00c8);
    check("t1_gate_time_hold", bus.gate_time, 8'h0a);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("t1_busy_done", busy, 0);
    check("t1_valid_done", bus.res_valid, 0);

    // Backpressure
    kick(8'h33, 1'b0);
    tick();
    result(64'hdead_beef_0123_4567);
    held = 64'hdead_beef_0123_4567;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!bus.res_valid || bus.res_data !== held || bus.gate_st) bad++;
    end
    check("t2_stable", bad, 0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("t2_drained", {busy, bus.res_valid}, 2'b00);

    // Timeout
    timeout = 32'd100;
    kick(8'h10, 1'b0);
    repeat (100) tick();
    check("t3_not_yet", {tmo, busy}, 2'b01);
    tick();
    check("t3_timeout", {tmo, busy, bus.res_valid}, 3'b100);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t3_clr", tmo, 0);
    kick(8'h11, 1'b0);
    repeat (100) tick();
    result(64'h0000_0000_0000_0abc);
    check("t3_race_valid", bus.res_valid, 1);
    check("t3_race_no_tmo", tmo, 0);
    check("t3_race_data", bus.res_data, 64'h0abc);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("t3_race_idle", busy, 0);
    timeout = '0;

    // Continuous with stop in the third WAIT
    bus.res_ready = 1'b1;
    kick(8'h22, 1'b1);
    check("t4_gate0", bus.gate_st, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_wait_gate", bus.gate_st, 0);
      repeat (3) tick();
      if (i == 2) stop = 1'b1;
      tick();
      stop = 1'b0;
      result(64'h100 + 64'(i));
      check("t4_valid", bus.res_valid, 1);
      check("t4_data", bus.res_data, 64'h100 + 64'(i));
      tick();
      check("t4_next_gate", bus.gate_st, (i != 2) ? 1'b1 : 1'b0);
      check("t4_busy", busy, (i != 2) ? 1'b1 : 1'b0);
    end
    bus.res_ready = 1'b0;

    // Stray and set-over-clear
    result(64'h5);
    check("t5_stray", {stray, bus.res_valid, busy}, 3'b100);
    clr = 1'b1;
    result(64'h6);
    clr = 1'b0;
    check("t5_set_wins", stray, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t5_clr", stray, 0);

    // Async reset while a result is held
    kick(8'h55, 1'b0);
    tick();
    result(64'h77);
    check("t5_held", bus.res_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_all", {busy, bus.res_valid, bus.gate_st, tmo, stray}, 5'b0);
    check("t5_rst_gate_time", bus.gate_time, 8'h00);
    check("t5_rst_data", bus.res_data, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef MEASURE_CTRL_FIFO_EN
    // FIFO: four results buffered under backpressure, fifth gate waits for a pop
    kick(8'h44, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      result(64'h200 + 64'(i));
    end
    check("t6_full_no_gate", bus.gate_st, 0);
    check("t6_head", bus.res_data, 64'h200);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.gate_st) bad++;
    end
    check("t6_stall", bad, 0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("t6_head_after_pop", bus.res_data, 64'h201);
    tick();
    check("t6_gate_after_pop", bus.gate_st, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    result(64'h204);
    check("t6_idle", busy, 0);
    bus.res_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      check("t6_order", bus.res_data, 64'h200 + 64'(j));
      tick();
    end
    bus.res_ready = 1'b0;
    check("t6_empty", bus.res_valid, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
